// File: rtl/inst_stream_encoder_pkg.sv
// Shared RV32I encoder definitions: format codes, error codes, FSM states,
// opcode constants, the descriptor record and the signed-range helper.
package inst_stream_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_IMM  = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_FMT  = 2'b11;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMI  = 7'b0010011;
    localparam logic [6:0] OP_OPRS2  = 7'b0110011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } desc_t;

    // True when v is a sign-extension of its low (top+1) bits.
    function automatic logic fits_signed(input logic [31:0] v, input int top);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 32; k++) begin
            ok = ok & ((k < top) | (v[k] == v[31]));
        end
        return ok;
    endfunction

endpackage

// File: rtl/inst_stream_encoder_if.sv
// Descriptor input channel, IMEM write channel and status of the encoder.
interface inst_stream_encoder_if #(parameter int ADDR_W = 10) ();
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W:0]   count;

    modport slave (
        input  start, in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done,
               err, err_code, err_addr, count
    );

    modport master (
        output start, in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
               in_rd, in_rs1, in_rs2, in_imm, in_last, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done,
               err, err_code, err_addr, count
    );
endinterface

// File: rtl/inst_stream_encoder_pack.sv
// Combinational RV32I packer: builds the instruction word for a descriptor
// and flags out-of-range immediates and unknown formats.
module inst_pack
    import inst_stream_encoder_pkg::*;
(
    input  desc_t       desc_i,
    output logic [31:0] word_o,
    output logic        range_err_o,
    output logic        fmt_err_o
);

    logic is_shift_s;

    // Only OP-IMM shifts carry funct7 in the immediate field; loads also use funct3=001/101.
    assign is_shift_s = (desc_i.opcode == OP_OPIMI) &&
                        ((desc_i.funct3 == 3'b001) || (desc_i.funct3 == 3'b101));

    // Format-selected packing and immediate range check.
    always_comb begin
        word_o      = 32'd0;
        range_err_o = 1'b0;
        fmt_err_o   = 1'b0;
        case (desc_i.fmt)
            FMT_R: begin
                word_o = {desc_i.funct7, desc_i.rs2, desc_i.rs1, desc_i.funct3,
                          desc_i.rd, desc_i.opcode};
            end
            FMT_I: begin
                if (is_shift_s) begin
                    word_o      = {desc_i.funct7, desc_i.imm[4:0], desc_i.rs1,
                                   desc_i.funct3, desc_i.rd, desc_i.opcode};
                    range_err_o = (desc_i.imm[31:5] != 27'd0);
                end else begin
                    word_o      = {desc_i.imm[11:0], desc_i.rs1, desc_i.funct3,
                                   desc_i.rd, desc_i.opcode};
                    range_err_o = !fits_signed(desc_i.imm, 11);
                end
            end
            FMT_S: begin
                word_o      = {desc_i.imm[11:5], desc_i.rs2, desc_i.rs1, desc_i.funct3,
                               desc_i.imm[4:0], desc_i.opcode};
                range_err_o = !fits_signed(desc_i.imm, 11);
            end
            FMT_B: begin
                word_o      = {desc_i.imm[12], desc_i.imm[10:5], desc_i.rs2, desc_i.rs1,
                               desc_i.funct3, desc_i.imm[4:1], desc_i.imm[11], desc_i.opcode};
                range_err_o = !fits_signed(desc_i.imm, 12) || desc_i.imm[0];
            end
            FMT_U: begin
                word_o      = {desc_i.imm[31:12], desc_i.rd, desc_i.opcode};
                range_err_o = (desc_i.imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word_o      = {desc_i.imm[20], desc_i.imm[10:1], desc_i.imm[11],
                               desc_i.imm[19:12], desc_i.rd, desc_i.opcode};
                range_err_o = !fits_signed(desc_i.imm, 20) || desc_i.imm[0];
            end
            default: begin
                fmt_err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_stream_encoder.sv
// Sequential loader: accepts descriptors, encodes them through inst_pack and
// writes them to consecutive IMEM words through a one-entry output register.
module inst_stream_encoder
    import inst_stream_encoder_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_stream_encoder_if.slave bus
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FULL_C = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_seen_q, last_seen_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    desc_t             desc_s;
    logic [31:0]       word_s;
    logic              range_err_s;
    logic              fmt_err_s;
    logic              wr_done_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              start_ok_s;
    logic              ovf_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [ADDR_W:0]   acc_cnt_s;

    assign desc_s = '{fmt:    bus.in_fmt,
                      opcode: bus.in_opcode,
                      funct3: bus.in_funct3,
                      funct7: bus.in_funct7,
                      rd:     bus.in_rd,
                      rs1:    bus.in_rs1,
                      rs2:    bus.in_rs2,
                      imm:    bus.in_imm};

    inst_pack u_pack (
        .desc_i      (desc_s),
        .word_o      (word_s),
        .range_err_o (range_err_s),
        .fmt_err_o   (fmt_err_s)
    );

    // A new descriptor lands where the pointer will be after any write completing this cycle.
    assign wr_done_s  = we_q && bus.imem_ready;
    assign in_ready_s = (state_q == ST_LOAD) && !last_seen_q && (!we_q || bus.imem_ready);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign start_ok_s = bus.start && (state_q != ST_LOAD);
    assign acc_addr_s = wr_done_s ? (ptr_q + ADDR_W'(1)) : ptr_q;
    assign acc_cnt_s  = cnt_q + (ADDR_W+1)'(wr_done_s);
    assign ovf_s      = (acc_cnt_s == FULL_C);

    // FSM next state, output register, pointer/counter and error capture.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_seen_d = last_seen_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        done_d      = 1'b0;
        if (start_ok_s) begin
            state_d     = ST_LOAD;
            ptr_d       = BASE_A;
            cnt_d       = '0;
            we_d        = 1'b0;
            last_seen_d = 1'b0;
            err_d       = 1'b0;
            err_code_d  = ERR_NONE;
            err_addr_d  = '0;
        end else begin
            if (wr_done_s) begin
                we_d  = 1'b0;
                ptr_d = ptr_q + ADDR_W'(1);
                cnt_d = acc_cnt_s;
            end else begin
                we_d  = we_q;
            end
            case (state_q)
                ST_LOAD: begin
                    if (accept_s) begin
                        if (fmt_err_s || ovf_s || range_err_s) begin
                            state_d    = ST_ERR;
                            err_d      = 1'b1;
                            err_addr_d = acc_addr_s;
                            if (fmt_err_s) begin
                                err_code_d = ERR_FMT;
                            end else if (ovf_s) begin
                                err_code_d = ERR_OVF;
                            end else begin
                                err_code_d = ERR_IMM;
                            end
                        end else begin
                            we_d        = 1'b1;
                            addr_d      = acc_addr_s;
                            wdata_d     = word_s;
                            last_seen_d = bus.in_last;
                        end
                    end else if (last_seen_q && wr_done_s) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_IDLE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d == ST_LOAD);
    end

    // State and output registers; reset drops any pending write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= BASE_A;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_addr_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_seen_q <= last_seen_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.err_addr   = err_addr_q;
    assign bus.count      = cnt_q;

endmodule

// File: doc/inst_stream_encoder.md
# inst_stream_encoder

Instruction encoder/loader that packs decoded RV32I fields (format, opcode, funct3/funct7, register indices, immediate) into 32-bit instruction words and writes them sequentially into instruction memory. It is the inverse of the instruction decoder: it builds the same encodings the decoder splits apart. It sits between a test or boot-program source and the IMEM write port. It accepts one descriptor per valid/ready handshake, range-checks immediates, and flags malformed descriptors without writing them.

## Interface
Parameters:
- ADDR_W, 10, IMEM word-address width
- BASE_ADDR, 0, first word address written after start

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a load at BASE_ADDR; ignored while busy
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid && in_ready
- in_fmt  in  3  FMT_R/I/S/B/U/J (define.vh)
- in_opcode  in  7  opcode field
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R, and I-shifts)
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_imm  in  32  signed byte-offset/immediate value, not pre-shifted
- in_last  in  1  final descriptor of the program
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state is LOAD
- done  out  1  one-cycle pulse after the last word is written
- err  out  1  sticky error flag, cleared by start
- err_code  out  2  01 imm range, 10 address overflow, 11 bad fmt
- err_addr  out  ADDR_W  address the failing word would have used
- count  out  ADDR_W+1  words written since start

## Operation
- States: IDLE, LOAD, DONE, ERR.
  - IDLE/DONE/ERR + start → LOAD: pointer=BASE_ADDR, count=0, err cleared.
  - DONE → IDLE after 1 cycle.
- Encoding:
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}; when f3 is 001 or 101, bits[31:25]=f7 and imm must be 0..31.
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- Range checks (err_code 01):
  - I/S: imm in −2048..2047
  - B: imm in −4096..4094, imm[0]=0
  - J: imm in −2^20..2^20−2, imm[0]=0
  - U: imm[11:0]=0
- fmt values 6 and 7 → err_code 11.
- Overflow: accepting a descriptor when count = 2^ADDR_W → err_code 10.
- On any error: descriptor consumed, no write issued, err_addr=pointer, state → ERR, in_ready=0. A word already in the output register still completes its write.
- Address wraps modulo 2^ADDR_W from BASE_ADDR; the count check prevents overwrite.
- After in_last is accepted: in_ready=0; after its write handshake → DONE.

## Timing
- One-entry output register.
  - in_ready = (state==LOAD) && !last_seen && (!imem_we || imem_ready).
  - Descriptor accepted in cycle N → imem_we, imem_addr, imem_wdata valid from cycle N+1.
  - A write completes on imem_we && imem_ready; pointer and count update on that edge.
- Back-to-back throughput is 1 word/cycle while imem_ready=1.
- imem_we=1 && imem_ready=0 → addr and wdata held stable, in_ready=0.
- Simultaneous write completion and new accept in the same cycle → register reloads with no bubble.
- start asserted in LOAD is ignored.
- Reset values: all outputs 0, state IDLE, pointer=BASE_ADDR.
- rst mid-load: pending word discarded immediately and imem_we drops asynchronously.

## Structure
- define.vh holds:
  - FMT_* codes
  - ERR_* codes
  - state encodings
  - the existing opcode macros (OPIMI, OPRS2, BRANCH, STORE, JAL, LUI…)
- Sub-module `inst_pack`: purely combinational format→word packer plus range checker (outputs word, range_err, fmt_err). The sequential top contains the FSM, output register, pointer and counter.

## Test plan
- ADDI x1,x0,5 (fmt I, op 0010011, f3 000, imm 5) → imem_wdata 0x00500093 at addr 0, one cycle after accept.
- ADD x3,x1,x2 → 0x002081B3.
- SW x2,12(x1) → 0x0020A623.
- BEQ x1,x2,+8 → 0x00208463.
- JAL x1,+2048 → 0x001000EF.
- Full stream with in_last, imem_ready=1 → one done pulse, count=5.
- ADDI imm 2048 at pointer 3 → err=1, err_code 01, err_addr 3, no imem_we for that word.
- BEQ imm 7 → err_code 01.
- imem_ready low for 3 cycles → wdata/addr stable, in_ready=0, no lost or duplicated word.
- ADDR_W=2, five descriptors → four writes, fifth gives err_code 10, err_addr 0.
- rst asserted with imem_we high → imem_we=0 immediately.
- After rst, start → writes resume at BASE_ADDR with count 0.
